// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD constants, FSM state type and nine's-complement helper
package bcd_pkg;
  localparam int BCD_W = 4;
  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] ADJ = 4'd6;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic [3:0] nines_comp(input logic [3:0] d);
    return DIGIT_MAX - d;
  endfunction
endpackage

// File: rtl/bcd_addsub_seq_if.sv
// bcd_addsub_seq_if: operand request and result handshake bundle for the BCD add/sub unit
interface bcd_addsub_seq_if
  import bcd_pkg::*;
#(
  parameter int DIGITS = 100
);
  logic in_valid;
  logic in_ready;
  logic [BCD_W*DIGITS-1:0] a;
  logic [BCD_W*DIGITS-1:0] b;
  logic cin;
  logic sub;
  logic out_valid;
  logic out_ready;
  logic [BCD_W*DIGITS-1:0] sum;
  logic cout;
  logic neg;
  logic err;
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input in_ready, out_valid, sum, cout, neg, err
  );
  modport slave (
    input in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, neg, err
  );
endinterface

// File: rtl/bcd_digit_cell.sv
// bcd_digit_cell: one decimal digit adder with carry, corrected by +6 when the binary sum exceeds 9
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a_d,
  input  logic [BCD_W-1:0] b_d,
  input  logic             cin,
  output logic [BCD_W-1:0] s_d,
  output logic             cout
);
  logic [BCD_W:0] s;
  always_comb begin
    s = {1'b0, a_d} + {1'b0, b_d} + {{BCD_W{1'b0}}, cin};
    cout = s > {1'b0, DIGIT_MAX};
    s_d = cout ? s[BCD_W-1:0] + ADJ : s[BCD_W-1:0];
  end
endmodule

// File: rtl/bcd_addsub_seq.sv
// bcd_addsub_seq: digit-serial packed-BCD adder/subtractor, DPC digits per clock,
// operands latched on a valid/ready handshake and the result held until consumed.
module bcd_addsub_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 100,
  parameter int DPC = 4
) (
  input logic clk,
  input logic areset_n,
  bcd_addsub_seq_if.slave bus
);
  localparam int ITER = DIGITS / DPC;
  localparam int CW = ITER > 1 ? $clog2(ITER) : 1;
  localparam int W = BCD_W * DIGITS;
  localparam int SW = BCD_W * DPC;
  if (DIGITS % DPC != 0) begin : g_bad_dpc
    $error("bcd_addsub_seq: DIGITS must be a multiple of DPC");
  end
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [W-1:0] a_r, b_r, b_x, sum_r;
  logic carry, sub_r, cout_r, neg_r, err_r, bad, last, accept, in_rdy;
  logic [DPC:0] c;
  logic [SW-1:0] a_s, b_s, s_s;
  // Subtraction as A + (nines complement of B) + 1; err looks at B before complementing
  always_comb begin
    b_x = bus.b;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      b_x[BCD_W*i +: BCD_W] = bus.sub ? nines_comp(bus.b[BCD_W*i +: BCD_W]) : bus.b[BCD_W*i +: BCD_W];
      bad = bad | (bus.a[BCD_W*i +: BCD_W] > DIGIT_MAX) | (bus.b[BCD_W*i +: BCD_W] > DIGIT_MAX);
    end
  end
  assign a_s = a_r[SW*int'(cnt) +: SW];
  assign b_s = b_r[SW*int'(cnt) +: SW];
  assign c[0] = carry;
  for (genvar d = 0; d < DPC; d++) begin : g_cell
    bcd_digit_cell u_cell (
      .a_d (a_s[BCD_W*d +: BCD_W]),
      .b_d (b_s[BCD_W*d +: BCD_W]),
      .cin (c[d]),
      .s_d (s_s[BCD_W*d +: BCD_W]),
      .cout(c[d+1])
    );
  end
  assign last = cnt == CW'(ITER - 1);
  assign in_rdy = areset_n && (state == IDLE || (state == DONE && bus.out_ready));
  assign accept = bus.in_valid && in_rdy;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (bus.in_valid ? RUN : IDLE) :
               state == RUN  ? (last ? DONE : RUN) :
               state == DONE ? (bus.out_ready ? (bus.in_valid ? RUN : IDLE) : DONE) : IDLE;
  end
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state <= IDLE;
      cnt <= '0;
      a_r <= '0;
      b_r <= '0;
      carry <= 1'b0;
      sub_r <= 1'b0;
      sum_r <= '0;
      cout_r <= 1'b0;
      neg_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_r <= bus.a;
        b_r <= b_x;
        carry <= bus.sub | bus.cin;
        sub_r <= bus.sub;
        err_r <= bad;
        cnt <= '0;
      end else if (state == RUN) begin
        sum_r[SW*int'(cnt) +: SW] <= s_s;
        carry <= c[DPC];
        cnt <= cnt + 1'b1;
        if (last) begin
          cout_r <= c[DPC];
          neg_r <= sub_r & ~c[DPC];
        end
      end
    end
  end
  assign bus.in_ready = in_rdy;
  assign bus.out_valid = state == DONE;
  assign bus.sum = sum_r;
  assign bus.cout = cout_r;
  assign bus.neg = neg_r;
  assign bus.err = err_r;
endmodule

// File: tb/tb_bcd_addsub_seq.sv
// tb_bcd_addsub_seq: directed checks on a 4-digit serial unit plus a decimal-model
// random run on an 8-digit, 2-digits-per-clock unit.
module tb_bcd_addsub_seq;
  logic clk = 1'b0;
  logic areset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  bcd_addsub_seq_if #(.DIGITS(4)) i1 ();
  bcd_addsub_seq_if #(.DIGITS(8)) i2 ();
  bcd_addsub_seq #(.DIGITS(4), .DPC(1)) u1 (.clk(clk), .areset_n(areset_n), .bus(i1));
  bcd_addsub_seq #(.DIGITS(8), .DPC(2)) u2 (.clk(clk), .areset_n(areset_n), .bus(i2));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send1(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub, output int k);
    @(negedge clk);
    i1.a = a; i1.b = b; i1.cin = cin; i1.sub = sub; i1.in_valid = 1'b1;
    k = 0;
    while (!i1.in_ready && k < 50) begin @(negedge clk); k++; end
    chk("accept1 wait bound", 32'(k < 50), 1);
    @(posedge clk);
    #1 i1.in_valid = 1'b0;
  endtask
  task automatic result1(input string tag, input logic [15:0] es, input logic ec, input logic en, input logic ee);
    int n;
    n = 0;
    while (!i1.out_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk({tag, " latency"}, n, 4);
    chk({tag, " sum"}, i1.sum, es);
    chk({tag, " cout/neg/err"}, {i1.cout, i1.neg, i1.err}, {ec, en, ee});
  endtask
  task automatic send2(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
    int k;
    @(negedge clk);
    i2.a = a; i2.b = b; i2.cin = cin; i2.sub = sub; i2.in_valid = 1'b1;
    k = 0;
    while (!i2.in_ready && k < 50) begin @(negedge clk); k++; end
    chk("accept2 wait bound", 32'(k < 50), 1);
    @(posedge clk);
    #1 i2.in_valid = 1'b0;
  endtask
  function automatic longint from_bcd(input logic [31:0] v);
    longint r;
    r = 0;
    for (int i = 7; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction
  function automatic logic [31:0] to_bcd(input longint x);
    logic [31:0] r;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction
  initial begin
    int k;
    logic [31:0] ra, rb, es;
    logic rc, rs, ec;
    longint r;
    i1.in_valid = 1'b0; i1.a = '0; i1.b = '0; i1.cin = 1'b0; i1.sub = 1'b0; i1.out_ready = 1'b1;
    i2.in_valid = 1'b0; i2.a = '0; i2.b = '0; i2.cin = 1'b0; i2.sub = 1'b0; i2.out_ready = 1'b1;
    #2;
    chk("reset in_ready", i1.in_ready, 0);
    chk("reset out_valid", i1.out_valid, 0);
    chk("reset sum", i1.sum, 0);
    chk("reset flags", {i1.cout, i1.neg, i1.err}, 0);
    repeat (2) @(negedge clk);
    areset_n = 1'b1;
    #1 chk("idle in_ready", i1.in_ready, 1);
    send1(16'h9999, 16'h0001, 1'b0, 1'b0, k);
    result1("add 9999+0001", 16'h0000, 1'b1, 1'b0, 1'b0);
    send1(16'h0100, 16'h0001, 1'b0, 1'b1, k);
    result1("sub 0100-0001", 16'h0099, 1'b1, 1'b0, 1'b0);
    send1(16'h0001, 16'h0002, 1'b0, 1'b1, k);
    result1("sub 0001-0002", 16'h9999, 1'b0, 1'b1, 1'b0);
    send1(16'h00A0, 16'h0000, 1'b1, 1'b0, k);
    result1("add 00A0 cin", 16'h0101, 1'b0, 1'b0, 1'b1);
    send1(16'h0000, 16'h000F, 1'b0, 1'b1, k);
    result1("sub 0000-000F", 16'h0001, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1 i1.out_ready = 1'b0;
    send1(16'h1234, 16'h4321, 1'b0, 1'b0, k);
    result1("add 1234+4321", 16'h5555, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("stall out_valid", i1.out_valid, 1);
      chk("stall sum", i1.sum, 16'h5555);
      chk("stall cout", i1.cout, 0);
      chk("stall in_ready", i1.in_ready, 0);
    end
    i1.out_ready = 1'b1;
    send1(16'h0500, 16'h0500, 1'b0, 1'b0, k);
    chk("back-to-back wait", k, 0);
    chk("back-to-back out_valid", i1.out_valid, 0);
    result1("add 0500+0500", 16'h1000, 1'b0, 1'b0, 1'b0);
    send1(16'h1111, 16'h2222, 1'b0, 1'b0, k);
    @(posedge clk);
    #1 areset_n = 1'b0;
    #1;
    chk("abort out_valid", i1.out_valid, 0);
    chk("abort sum", i1.sum, 0);
    chk("abort in_ready", i1.in_ready, 0);
    chk("abort flags", {i1.cout, i1.neg, i1.err}, 0);
    repeat (2) @(negedge clk);
    areset_n = 1'b1;
    @(negedge clk);
    chk("post-reset in_ready", i1.in_ready, 1);
    chk("post-reset out_valid", i1.out_valid, 0);
    send1(16'h0123, 16'h0456, 1'b1, 1'b0, k);
    result1("add 0123+0456+1", 16'h0580, 1'b0, 1'b0, 1'b0);
    send1(16'h0000, 16'h0000, 1'b0, 1'b1, k);
    result1("sub 0000-0000", 16'h0000, 1'b1, 1'b0, 1'b0);
    for (int op = 0; op < 1000; op++) begin
      int n, st;
      for (int i = 0; i < 8; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(0, 9));
        rb[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      r = rs ? from_bcd(ra) + (64'd99999999 - from_bcd(rb)) + 1 : from_bcd(ra) + from_bcd(rb) + longint'(rc);
      ec = r >= 64'd100000000;
      es = to_bcd(r % 64'd100000000);
      send2(ra, rb, rc, rs);
      n = 0;
      while (!i2.out_valid && n < 50) begin @(posedge clk); #1; n++; end
      chk("rand latency", n, 4);
      chk("rand sum", i2.sum, es);
      chk("rand cout/neg/err", {i2.cout, i2.neg, i2.err}, {ec, rs & ~ec, 1'b0});
      st = $urandom_range(0, 2);
      if (st > 0) begin
        i2.out_ready = 1'b0;
        repeat (st) begin @(posedge clk); #1; end
        chk("rand held sum", i2.sum, es);
        i2.out_ready = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
